// File: rtl/tpm_sync_controller_pkg.sv
// Shared definitions for the tree-parity-machine key-exchange controller:
// FSM state encoding, one-hot ctrl phase codes and common widths.
package tpm_pkg;

  localparam int FEED_W  = 6;
  localparam int ROUND_W = 16;

  // One-hot phase codes broadcast to both partners
  localparam logic [2:0] CTRL_IDLE    = 3'b000;
  localparam logic [2:0] CTRL_COMPUTE = 3'b001;
  localparam logic [2:0] CTRL_UPDATE  = 3'b010;
  localparam logic [2:0] CTRL_FINISH  = 3'b100;

  // Controller states
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_FEED     = 3'd1;
  localparam logic [2:0] ST_COMPUTE  = 3'd2;
  localparam logic [2:0] ST_EXCHANGE = 3'd3;
  localparam logic [2:0] ST_UPDATE   = 3'd4;
  localparam logic [2:0] ST_CHECK    = 3'd5;
  localparam logic [2:0] ST_FINISH   = 3'd6;
  localparam logic [2:0] ST_ABORT    = 3'd7;

  // Phase code the partners see while the controller sits in a given state
  function automatic logic [2:0] ctrl_for(input logic [2:0] st);
    case (st)
      ST_COMPUTE: ctrl_for = CTRL_COMPUTE;
      ST_UPDATE:  ctrl_for = CTRL_UPDATE;
      ST_FINISH:  ctrl_for = CTRL_FINISH;
      default:    ctrl_for = CTRL_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/tpm_sync_controller_if.sv
// Bus between the sync controller and the key-exchange top level: start
// request, partner outputs/dirty flags in, feed/ctrl/routing/status out.
interface tpm_sync_controller_if;
  import tpm_pkg::*;

  logic               start;
  logic               out_a;
  logic               out_b;
  logic               dirty_a;
  logic               dirty_b;
  logic [FEED_W-1:0]  feed;
  logic [2:0]         ctrl;
  logic               out_other_a;
  logic               out_other_b;
  logic               busy;
  logic               done;
  logic               synced;
  logic               fail;
  logic [ROUND_W-1:0] round_cnt;

  // Controller side: sequences the partners
  modport master (
    input  start, out_a, out_b, dirty_a, dirty_b,
    output feed, ctrl, out_other_a, out_other_b, busy, done, synced, fail,
           round_cnt
  );

  // Environment side: partners plus whoever kicks off the exchange
  modport slave (
    output start, out_a, out_b, dirty_a, dirty_b,
    input  feed, ctrl, out_other_a, out_other_b, busy, done, synced, fail,
           round_cnt
  );

endinterface

// File: rtl/tpm_feed_lfsr.sv
// Shared feed generator: 6-bit Fibonacci LFSR, x^6+x^5+1, shifting left.
// Advances only when step is high; a zero seed is replaced by 1 so the
// register can never lock up in the all-zero state.
module tpm_feed_lfsr
  import tpm_pkg::*;
#(
  parameter logic [FEED_W-1:0] SEED = 6'b110100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              step,
  output logic [FEED_W-1:0] state
);

  localparam logic [FEED_W-1:0] SEED_EFF =
    (SEED == '0) ? FEED_W'(1) : SEED;

  logic fb;

  assign fb = state[FEED_W-1] ^ state[FEED_W-2];

  // Load the seed on reset, otherwise shift in the feedback bit on step
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SEED_EFF;
    end else if (step) begin
      state <= {state[FEED_W-2:0], fb};
    end
  end

endmodule

// File: rtl/tpm_sync_controller.sv
// Round sequencer for two tree-parity-machine partners. Each round:
// FEED (LFSR step) -> COMPUTE (ctrl=001) -> EXCHANGE (swap outputs) ->
// UPDATE (ctrl=010, only when outputs agree) -> CHECK. Declares sync after
// SYNC_ROUNDS consecutive agreeing rounds, or failure after MAX_ROUNDS.
module tpm_sync_controller
  import tpm_pkg::*;
#(
  parameter logic [FEED_W-1:0] LFSR_SEED      = 6'b110100,
  parameter int                COMPUTE_CYCLES = 6,
  parameter int                UPDATE_CYCLES  = 6,
  parameter int                SYNC_ROUNDS    = 20,
  parameter int                MAX_ROUNDS     = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  tpm_sync_controller_if.master bus
);

  localparam int PH_MAX = (COMPUTE_CYCLES > UPDATE_CYCLES) ?
                          COMPUTE_CYCLES : UPDATE_CYCLES;
  localparam int PH_W   = $clog2(PH_MAX + 1);

  logic [2:0]         state;
  logic [2:0]         state_next;
  logic [2:0]         ctrl_q;
  logic               busy_q;
  logic               done_q;
  logic               synced_q;
  logic               fail_q;
  logic               out_other_a_q;
  logic               out_other_b_q;
  logic [ROUND_W-1:0] round_cnt;
  logic [ROUND_W-1:0] match_cnt;
  logic [PH_W-1:0]    phase_cnt;
  logic [FEED_W-1:0]  feed;

  logic               phase_last_c;
  logic               phase_last_u;
  logic               outs_agree;
  logic               goto_finish;
  logic               goto_abort;
  logic               feed_step;

  assign phase_last_c = (phase_cnt == PH_W'(COMPUTE_CYCLES - 1));
  assign phase_last_u = (phase_cnt == PH_W'(UPDATE_CYCLES - 1));
  assign outs_agree   = (bus.out_a == bus.out_b);

  // Sync takes priority over the round limit when both hit in one round
  assign goto_finish  = (state == ST_CHECK) &&
                        (match_cnt >= ROUND_W'(SYNC_ROUNDS));
  assign goto_abort   = (state == ST_CHECK) && !goto_finish &&
                        (round_cnt >= ROUND_W'(MAX_ROUNDS));
  assign feed_step    = (state == ST_FEED);

  tpm_feed_lfsr #(
    .SEED (LFSR_SEED)
  ) u_feed_lfsr (
    .clk   (clk),
    .rst   (rst),
    .step  (feed_step),
    .state (feed)
  );

  // Next-state decode for the round sequence
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:     if (bus.start) state_next = ST_FEED;
      ST_FEED:     state_next = ST_COMPUTE;
      ST_COMPUTE:  if (phase_last_c) state_next = ST_EXCHANGE;
      ST_EXCHANGE: state_next = outs_agree ? ST_UPDATE : ST_CHECK;
      ST_UPDATE:   if (phase_last_u) state_next = ST_CHECK;
      ST_CHECK: begin
        if (goto_finish)     state_next = ST_FINISH;
        else if (goto_abort) state_next = ST_ABORT;
        else                 state_next = ST_FEED;
      end
      ST_FINISH:   state_next = ST_IDLE;
      ST_ABORT:    state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
  end

  // State register with ctrl/busy/done registered from the next state so
  // they line up with the state they describe and never glitch
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      ctrl_q <= CTRL_IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_next;
      ctrl_q <= ctrl_for(state_next);
      busy_q <= (state_next != ST_IDLE);
      done_q <= (state_next == ST_FINISH) || (state_next == ST_ABORT);
    end
  end

  // Phase counter: times the COMPUTE and UPDATE windows, zero elsewhere
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_cnt <= '0;
    end else if ((state == ST_COMPUTE && !phase_last_c) ||
                 (state == ST_UPDATE  && !phase_last_u)) begin
      phase_cnt <= phase_cnt + 1'b1;
    end else begin
      phase_cnt <= '0;
    end
  end

  // Round and agreement bookkeeping plus the sticky result flags
  always_ff @(posedge clk) begin
    if (rst) begin
      round_cnt <= '0;
      match_cnt <= '0;
      synced_q  <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            round_cnt <= '0;
            match_cnt <= '0;
            synced_q  <= 1'b0;
            fail_q    <= 1'b0;
          end
        end
        ST_EXCHANGE: begin
          if (round_cnt != '1) round_cnt <= round_cnt + 1'b1;
          if (!outs_agree)            match_cnt <= '0;
          else if (match_cnt != '1)   match_cnt <= match_cnt + 1'b1;
        end
        ST_UPDATE: begin
          // Partners that disagree on whether weights moved have diverged
          if (phase_last_u && (bus.dirty_a != bus.dirty_b)) match_cnt <= '0;
        end
        ST_CHECK: begin
          if (goto_finish) synced_q <= 1'b1;
          if (goto_abort)  fail_q   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Cross-route partner outputs, held until the next EXCHANGE
  always_ff @(posedge clk) begin
    if (rst) begin
      out_other_a_q <= 1'b0;
      out_other_b_q <= 1'b0;
    end else if (state == ST_EXCHANGE) begin
      out_other_a_q <= bus.out_b;
      out_other_b_q <= bus.out_a;
    end
  end

  assign bus.feed        = feed;
  assign bus.ctrl        = ctrl_q;
  assign bus.out_other_a = out_other_a_q;
  assign bus.out_other_b = out_other_b_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.synced      = synced_q;
  assign bus.fail        = fail_q;
  assign bus.round_cnt   = round_cnt;

endmodule

// File: doc/tpm_sync_controller.md
Name: tpm_sync_controller

Overview:
Sequences two `partner` tree-parity-machine instances (A and B) through the neural key-agreement protocol. Each round it does four things:
- generates the shared random `feed` vector;
- drives the one-hot `ctrl` phases;
- cross-routes each partner's `out` to the other's `out_other`;
- counts consecutive agreeing rounds.

It declares sync or failure and pulses `done`. It sits directly above the two partners in the key-exchange top level.

Parameters:
- FEED_W, 6, width of shared feed vector; the LFSR polynomial is fixed for 6 bits.
- LFSR_SEED, 6'b110100, initial LFSR state; a zero seed is replaced by 6'b000001.
- COMPUTE_CYCLES, 6, clocks that ctrl=3'b001 is held per round.
- UPDATE_CYCLES, 6, clocks that ctrl=3'b010 is held per round.
- SYNC_ROUNDS, 20, consecutive agreeing rounds required to declare sync.
- MAX_ROUNDS, 1000, round limit before fail; ROUND_W=16 bits.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin an exchange; sampled only in IDLE.
- out_a  in  1  partner A parity output.
- out_b  in  1  partner B parity output.
- dirty_a  in  1  partner A weights modified in the current update.
- dirty_b  in  1  partner B weights modified in the current update.
- feed  out  FEED_W  shared input vector to both partners.
- ctrl  out  3  one-hot phase to both partners: 001 compute, 010 update, 100 finish, 000 idle.
- out_other_a  out  1  registered copy of out_b, fed to A.
- out_other_b  out  1  registered copy of out_a, fed to B.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at the end of an exchange.
- synced  out  1  sticky success flag; cleared on start.
- fail  out  1  sticky failure flag; cleared on start.
- round_cnt  out  ROUND_W  rounds completed in the current exchange.

Behaviour:
- Reset (clk edge with rst=1) applies these values:
  - state=IDLE; ctrl=000; feed=LFSR_SEED (or 1 if the seed is zero).
  - out_other_a=out_other_b=0; busy=done=synced=fail=0.
  - round_cnt=0; match_cnt=0; phase counter=0.
- Reset mid-exchange aborts immediately. No done pulse is issued.
- LFSR: Fibonacci, taps x^6+x^5+1, shifting left; new bit = feed[5]^feed[4]. It advances only in FEED. The all-zero state is unreachable.
- IDLE:
  - ctrl=000.
  - start=1: clear synced, fail, round_cnt, match_cnt, then go to FEED. start seen in any other state is ignored.
- FEED (1 cycle):
  - LFSR steps; the new feed is visible from the next cycle.
  - Go to COMPUTE.
- COMPUTE:
  - ctrl=001 for exactly COMPUTE_CYCLES cycles, counted by the phase counter.
  - feed is held stable.
  - Then go to EXCHANGE.
- EXCHANGE (1 cycle):
  - ctrl=000.
  - Sample out_a and out_b. Register out_other_a<=out_b and out_other_b<=out_a; hold them until the next EXCHANGE.
  - round_cnt increments, saturating at 2^ROUND_W-1.
  - If out_a==out_b: match_cnt increments, then go to UPDATE.
  - Otherwise: match_cnt=0, then go to CHECK (no update).
- UPDATE:
  - ctrl=010 for UPDATE_CYCLES cycles.
  - On the last cycle, sample dirty_a and dirty_b. If they differ, match_cnt=0 (the partners diverged).
  - Go to CHECK.
- CHECK (1 cycle, ctrl=000):
  - If match_cnt>=SYNC_ROUNDS, go to FINISH. Sync wins if the round limit is reached in the same round.
  - Else if round_cnt>=MAX_ROUNDS, go to ABORT.
  - Else go to FEED.
- FINISH (1 cycle):
  - ctrl=100; synced<=1; done pulse.
  - Go to IDLE.
- ABORT (1 cycle):
  - ctrl=000; fail<=1; done pulse.
  - Go to IDLE.
- ctrl is always one-hot or zero and is registered (glitch-free).
- Round latency:
  - agreeing round: COMPUTE_CYCLES+UPDATE_CYCLES+3 clocks (FEED+EXCHANGE+CHECK);
  - disagreeing round: COMPUTE_CYCLES+3 clocks.
- busy=0 only in IDLE. done and busy are never high together in IDLE.

Decomposition:
- Shared package tpm_pkg holds:
  - the state encoding (IDLE, FEED, COMPUTE, EXCHANGE, UPDATE, CHECK, FINISH, ABORT);
  - the ctrl constants CTRL_IDLE=3'b000, CTRL_COMPUTE=3'b001, CTRL_UPDATE=3'b010, CTRL_FINISH=3'b100;
  - FEED_W.
- One natural sub-module: tpm_feed_lfsr, with inputs clk, rst, step, and output FEED_W-wide state, plus the seed parameter.

Test Plan:
- Reset then idle: rst high 10 cycles, release, start=0 for 20 cycles -> ctrl=000, feed=6'b110100, busy=0, done never asserted.
- Sync path: SYNC_ROUNDS=3, out_a=out_b=1, dirty_a=dirty_b=1, pulse start -> three rounds of 6x001, 1x000, 6x010 each; then ctrl=100 for 1 cycle; synced=1, done one pulse, round_cnt=3, out_other_a=out_other_b=1.
- Disagreement reset: out_a=1, out_b=0 in round 2 of 3 (agreeing otherwise) -> round 2 shows no 010 phase and match_cnt resets; sync is reached at round_cnt=5.
- Fail path: MAX_ROUNDS=4, out_a!=out_b always -> four rounds, no 010 ever; fail=1, synced=0, done pulses once, return to IDLE.
- Dirty divergence: outputs equal every round, dirty_a!=dirty_b in round 2, SYNC_ROUNDS=3 -> synced asserted only after round 5.
- Robustness: start pulsed mid-COMPUTE is ignored; rst asserted mid-UPDATE -> next cycle ctrl=000, busy=0, no done; LFSR sequence from seed 110100 matches the reference model for 63 steps and then repeats.
